// File: rtl/risc_pkg.sv
// risc_pkg: types and default sizes shared by the fetch unit and the
// branch unit. The branch unit produces exNPC at DEF_PC_W bits, so both
// blocks size their program counters from the same default.
//
// Contents:
//   DEF_PC_W, DEF_INSTR_W, DEF_RESET_PC : default parameter values
//   fetch_state_t                       : fetch FSM state encoding
//   sat_inc8                            : 8-bit saturating increment
package risc_pkg;

  localparam int DEF_PC_W     = 10;
  localparam int DEF_INSTR_W  = 32;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    S_ISSUE  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } fetch_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC and issues one word read at a time to instruction memory.
// The fetched word is presented to decode on a valid/ready handshake.
// Branch-unit redirects (PCSrc/exNPC) reload the PC, squash a read that
// is in flight and flush a held instruction. halt stops new fetches; once
// the current read and any held instruction are finished, the unit parks
// in HALTED until rst.
//
// Ports:
//   clk, rst              clock / asynchronous active-high reset
//   PCSrc, exNPC          redirect strobe and target from branch unit
//   halt                  level request to stop fetching
//   imem_req, imem_addr   registered one-cycle read request
//   imem_rvalid, imem_rdata  read response
//   if_valid, if_ready    handshake to decode
//   if_instr, if_pc, if_npc  fetched word, its address, address+1
//   squash_cnt            saturating count of discarded fetches
module fetch_unit
  import risc_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCSrc,
  input  logic [PC_W-1:0]    exNPC,
  input  logic               halt,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_npc,
  output logic [7:0]         squash_cnt
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               squash_q, squash_d;
  logic [7:0]         squash_cnt_q, squash_cnt_d;
  logic               imem_req_q, imem_req_d;
  logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [PC_W-1:0]    if_npc_q, if_npc_d;

  // Set when the next cycle is an ISSUE cycle carrying a request to pc_d.
  logic               start_fetch;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_ISSUE;
      pc_q         <= RST_PC;
      squash_q     <= 1'b0;
      squash_cnt_q <= 8'd0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RST_PC;
      if_instr_q   <= '0;
      if_pc_q      <= RST_PC;
      if_npc_q     <= RST_PC + PC_ONE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      squash_q     <= squash_d;
      squash_cnt_q <= squash_cnt_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_npc_q     <= if_npc_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and datapath
  // The request is registered on entry to ISSUE, so imem_req is high for
  // exactly the ISSUE cycle. Out of reset ISSUE starts with no request on
  // the bus; that cycle only launches one. Every path back into ISSUE is
  // gated by halt, and a blocked path goes straight to HALTED.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    squash_d     = squash_q;
    squash_cnt_d = squash_cnt_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_npc_d     = if_npc_q;
    start_fetch  = 1'b0;

    case (state_q)
      S_ISSUE: begin
        if (imem_req_q) begin
          // Request is on the bus now; a redirect must kill its response.
          state_d = S_WAIT;
          if (PCSrc) begin
            pc_d     = exNPC;
            squash_d = 1'b1;
          end
        end else begin
          // Nothing in flight: a redirect only reloads the PC.
          if (PCSrc) begin
            pc_d = exNPC;
          end
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            start_fetch = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (squash_q || PCSrc) begin
            // Wrong-path word: drop it and refetch from the (new) pc.
            squash_d     = 1'b0;
            squash_cnt_d = sat_inc8(squash_cnt_q);
            if (PCSrc) begin
              pc_d = exNPC;
            end
            if (halt) begin
              state_d = S_HALTED;
            end else begin
              state_d     = S_ISSUE;
              start_fetch = 1'b1;
            end
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_npc_d   = pc_q + PC_ONE;
            pc_d       = pc_q + PC_ONE;
            state_d    = S_HOLD;
          end
        end else if (PCSrc) begin
          pc_d     = exNPC;
          squash_d = 1'b1;
        end
      end

      S_HOLD: begin
        // if_valid is already masked by PCSrc, so no handshake can
        // coincide with a flush.
        if (PCSrc || if_ready) begin
          if (PCSrc) begin
            pc_d         = exNPC;
            squash_cnt_d = sat_inc8(squash_cnt_q);
          end
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            state_d     = S_ISSUE;
            start_fetch = 1'b1;
          end
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    imem_req_d  = start_fetch;
    imem_addr_d = start_fetch ? pc_d : imem_addr_q;
    if_valid    = (state_q == S_HOLD) && !PCSrc;
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign if_instr   = if_instr_q;
  assign if_pc      = if_pc_q;
  assign if_npc     = if_npc_q;
  assign squash_cnt = squash_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A behavioural memory
// answers each request after mem_lat cycles with {mem_tag, addr}.
// Expected request addresses and expected decode transfers are queued
// ahead of each step; a negedge monitor pops and compares them.
module tb_fetch_unit;
  import risc_pkg::*;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               PCSrc = 1'b0;
  logic [PC_W-1:0]    exNPC = '0;
  logic               halt = 1'b0;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid = 1'b0;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               if_valid;
  logic               if_ready = 1'b0;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [PC_W-1:0]    if_npc;
  logic [7:0]         squash_cnt;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .exNPC(exNPC), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_npc(if_npc), .squash_cnt(squash_cnt)
  );

  // ---------------- memory model ----------------
  int                 mem_lat  = 1;
  logic [15:0]        mem_tag  = 16'h0000;
  int                 mem_cnt  = 0;
  logic [INSTR_W-1:0] mem_data = '0;

  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (mem_cnt == 1) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= mem_data;
    end
    if (mem_cnt > 0) mem_cnt <= mem_cnt - 1;
    if (imem_req) begin
      if (mem_lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= {mem_tag, 6'd0, imem_addr};
        mem_cnt     <= 0;
      end else begin
        mem_cnt  <= mem_lat - 1;
        mem_data <= {mem_tag, 6'd0, imem_addr};
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    npc;
  } xfer_t;

  xfer_t           exp_xfer[$];
  logic [PC_W-1:0] exp_req[$];
  int              req_cyc[$];
  int              hs_cyc[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic xfer_t mk(input int a, input logic [15:0] tag, input int n);
    xfer_t x;
    x.pc    = PC_W'(a);
    x.instr = {tag, 6'd0, PC_W'(a)};
    x.npc   = PC_W'(n);
    return x;
  endfunction

  always @(negedge clk) begin
    if (!rst && imem_req === 1'b1) begin
      req_cyc.push_back(cyc);
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        logic [PC_W-1:0] e;
        e = exp_req.pop_front();
        $display("REQ  cyc=%0d addr=%0d expect=%0d", cyc, imem_addr, e);
        chk("req_addr", 32'(imem_addr), 32'(e));
      end
    end
    if (!rst && if_valid === 1'b1 && if_ready === 1'b1) begin
      hs_cyc.push_back(cyc);
      if (exp_xfer.size() == 0) begin
        chk("xfer_unexpected", 32'(if_pc), 32'hFFFF_FFFF);
      end else begin
        xfer_t x;
        x = exp_xfer.pop_front();
        $display("XFER cyc=%0d pc=%0d instr=0x%0h npc=%0d", cyc, if_pc, if_instr, if_npc);
        chk("xfer_pc", 32'(if_pc), 32'(x.pc));
        chk("xfer_instr", if_instr, x.instr);
        chk("xfer_npc", 32'(if_npc), 32'(x.npc));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [PC_W-1:0] a, input string tag);
    int n = 0;
    while (!(imem_req === 1'b1 && imem_addr === a) && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'({imem_req, imem_addr}), 32'({1'b1, a}));
  endtask

  task automatic wait_hold(input logic [PC_W-1:0] a, input string tag);
    int n = 0;
    while (!(if_valid === 1'b1 && if_pc === a) && n < 60) begin
      step();
      n++;
    end
    chk(tag, 32'({if_valid, if_pc}), 32'({1'b1, a}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    if_ready = 1'b1;
    repeat (3) step();

    // reset state
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_npc", 32'(if_npc), 32'd1);
    chk("rst_squash", 32'(squash_cnt), 32'd0);

    // expected traffic for the main run
    for (int a = 0; a <= 5; a++) exp_req.push_back(PC_W'(a));
    exp_req.push_back(10'd150);
    exp_req.push_back(10'd120);
    exp_req.push_back(10'd150);
    exp_req.push_back(10'd151);
    exp_req.push_back(10'd1023);
    exp_req.push_back(10'd0);
    for (int a = 0; a <= 4; a++) exp_xfer.push_back(mk(a, 16'h0000, a + 1));
    exp_xfer.push_back(mk(150, 16'h0000, 151));
    exp_xfer.push_back(mk(1023, 16'h0000, 0));
    exp_xfer.push_back(mk(0, 16'h0000, 1));

    rst = 1'b0;

    // sequential fetch, 1-cycle memory
    wait_req(10'd5, "reach_addr5");
    chk("lat_req_to_xfer", 32'(hs_cyc[0] - req_cyc[0]), 32'd2);
    chk("req_period", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
    chk("xfer_period", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);

    // redirect while the addr-5 read returns
    step();
    PCSrc = 1'b1; exNPC = 10'd150;
    step();
    PCSrc = 1'b0; if_ready = 1'b0;
    chk("squash_after_5", 32'(squash_cnt), 32'd1);
    chk("redir_req_150", 32'({imem_req, imem_addr}), 32'({1'b1, 10'd150}));

    // flush held instruction 150, refetch 120
    wait_hold(10'd150, "hold_150");
    PCSrc = 1'b1; exNPC = 10'd120;
    #1;
    chk("flush_valid_150", 32'(if_valid), 32'd0);
    step();
    PCSrc = 1'b0;
    chk("squash_after_150", 32'(squash_cnt), 32'd2);
    chk("redir_req_120", 32'({imem_req, imem_addr}), 32'({1'b1, 10'd120}));

    // flush held instruction 120, refetch 150 and deliver it
    wait_hold(10'd120, "hold_120");
    chk("npc_120", 32'(if_npc), 32'd121);
    PCSrc = 1'b1; exNPC = 10'd150;
    #1;
    chk("flush_valid_120", 32'(if_valid), 32'd0);
    step();
    PCSrc = 1'b0; if_ready = 1'b1;
    chk("squash_after_120", 32'(squash_cnt), 32'd3);
    chk("redir_req_150b", 32'({imem_req, imem_addr}), 32'({1'b1, 10'd150}));

    // PC wrap at 1023
    wait_req(10'd151, "req_151");
    step();
    PCSrc = 1'b1; exNPC = 10'd1023;
    step();
    PCSrc = 1'b0;
    chk("squash_after_151", 32'(squash_cnt), 32'd4);
    chk("redir_req_1023", 32'({imem_req, imem_addr}), 32'({1'b1, 10'd1023}));
    wait_hold(10'd1023, "hold_1023");
    chk("npc_wrap", 32'(if_npc), 32'd0);
    wait_req(10'd0, "wrap_req_0");

    // halt during WAIT: word still delivered, then HALTED
    step();
    halt = 1'b1; if_ready = 1'b0;
    repeat (3) step();
    chk("halt_hold_valid", 32'(if_valid), 32'd1);
    chk("halt_hold_pc", 32'(if_pc), 32'd0);
    if_ready = 1'b1;
    step();
    chk("halted_valid", 32'(if_valid), 32'd0);
    chk("halted_req", 32'(imem_req), 32'd0);
    PCSrc = 1'b1; exNPC = 10'd7; halt = 1'b0;
    step();
    PCSrc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("halted_no_req", 32'(imem_req), 32'd0);
    end
    chk("halted_squash", 32'(squash_cnt), 32'd4);

    // reset during WAIT with a late response
    exp_req.push_back(10'd0);
    exp_req.push_back(10'd0);
    exp_xfer.push_back(mk(0, 16'h0000, 1));
    mem_lat = 3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_req(10'd0, "req_before_rst");
    mem_tag = 16'hDEAD;
    step();
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(imem_req), 32'd0);
    chk("rst_mid_squash", 32'(squash_cnt), 32'd0);
    step();
    rst = 1'b0; mem_tag = 16'h0000;
    wait_req(10'd0, "req_after_rst");
    halt = 1'b1;
    wait_hold(10'd0, "hold_after_rst");
    chk("instr_after_rst", if_instr, 32'd0);
    repeat (4) step();
    chk("squash_after_rst", 32'(squash_cnt), 32'd0);
    chk("final_valid", 32'(if_valid), 32'd0);

    chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
    chk("xfer_queue_empty", 32'(exp_xfer.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
